// File: rtl/log_reader_entry_fetch_if.sv
// Bundle of the request, log-memory and write-header FIFO channels of the
// log reader entry fetcher. 'master' is the fetcher side, 'slave' the side
// that serves it (request source, log memory and FIFO).
interface log_reader_entry_fetch_if #(
    parameter int DATA_W = 512,
    parameter int IDX_W  = 10,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 12
);
    // Read request
    logic              req_val;
    logic [IDX_W-1:0]  req_start_idx;
    logic [CNT_W-1:0]  req_num_entries;
    logic              req_rdy;
    // Log memory read request / response
    logic              rd_req_val;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_rdy;
    logic              rd_resp_val;
    logic [DATA_W-1:0] rd_resp_data;
    logic              rd_resp_rdy;
    // Write-header FIFO push side
    logic              hdr_fifo_wr_val;
    logic [DATA_W-1:0] hdr_fifo_wr_data;
    logic              hdr_fifo_wr_last;
    logic              hdr_fifo_wr_last_entry;
    logic              hdr_fifo_wr_rdy;
    // Completion
    logic              fetch_done;

    modport master (
        input  req_val, req_start_idx, req_num_entries,
        output req_rdy,
        output rd_req_val, rd_req_addr,
        input  rd_req_rdy,
        input  rd_resp_val, rd_resp_data,
        output rd_resp_rdy,
        output hdr_fifo_wr_val, hdr_fifo_wr_data, hdr_fifo_wr_last, hdr_fifo_wr_last_entry,
        input  hdr_fifo_wr_rdy,
        output fetch_done
    );

    modport slave (
        output req_val, req_start_idx, req_num_entries,
        input  req_rdy,
        input  rd_req_val, rd_req_addr,
        output rd_req_rdy,
        output rd_resp_val, rd_resp_data,
        input  rd_resp_rdy,
        input  hdr_fifo_wr_val, hdr_fifo_wr_data, hdr_fifo_wr_last, hdr_fifo_wr_last_entry,
        output hdr_fifo_wr_rdy,
        input  fetch_done
    );
endinterface

// File: rtl/log_reader_entry_fetch.sv
// Log reader entry fetcher: walks a circular log of fixed-size entry slots,
// one memory read outstanding at a time, and pushes each fetched line into
// the write-header FIFO tagged with end-of-entry and final-entry flags.
// The number of lines per entry comes from the byte length in the low bits
// of the entry's first line, rounded up to whole lines and clamped to
// [1, ENTRY_LINES].
module log_reader_entry_fetch #(
    parameter int DATA_W      = 512,
    parameter int LOG_ENTRIES = 1024,
    parameter int ENTRY_LINES = 4,
    parameter int LEN_W       = 16,
    parameter int IDX_W       = 10,
    parameter int CNT_W       = 8,
    parameter int ADDR_W      = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    log_reader_entry_fetch_if.master   bus
);

    localparam int LINE_W  = $clog2(ENTRY_LINES);
    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);

    localparam logic [LEN_W:0]    ROUND_UP  = (LEN_W+1)'(BYTES - 1);
    localparam logic [LEN_W:0]    MAX_LINES = (LEN_W+1)'(ENTRY_LINES);
    localparam logic [LINE_W-1:0] LAST_SLOT = LINE_W'(ENTRY_LINES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LOG_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ_LINE,
        WAIT_LINE,
        PUSH_LINE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] last_line_q, last_line_d;
    logic              fetch_done_q, fetch_done_d;
    logic [DATA_W-1:0] data_q;
    logic              data_en;

    logic [LEN_W:0]    len_lines;
    logic [LINE_W-1:0] resp_last_line;
    logic              is_last_line;
    logic              is_last_entry;

    // Index of the final line of an entry, derived from the length field of its first line.
    always_comb begin
        len_lines = ({1'b0, bus.rd_resp_data[LEN_W-1:0]} + ROUND_UP) >> BYTE_SH;
        if (len_lines == '0) begin
            resp_last_line = '0;
        end else if (len_lines >= MAX_LINES) begin
            resp_last_line = LAST_SLOT;
        end else begin
            resp_last_line = LINE_W'(len_lines - (LEN_W+1)'(1));
        end
    end

    assign is_last_line  = (line_q == last_line_q);
    assign is_last_entry = (remaining_q == CNT_W'(1));

    // Next-state and output decode; outputs depend on state only, never on a ready input.
    always_comb begin
        // NOTE: every _d signal and output gets a default before the case so no latch is inferred.
        state_d      = state_q;
        idx_d        = idx_q;
        remaining_d  = remaining_q;
        line_d       = line_q;
        last_line_d  = last_line_q;
        fetch_done_d = 1'b0;
        data_en      = 1'b0;

        bus.req_rdy                = 1'b0;
        bus.rd_req_val             = 1'b0;
        bus.rd_req_addr            = ADDR_W'({idx_q, line_q});
        bus.rd_resp_rdy            = 1'b0;
        bus.hdr_fifo_wr_val        = 1'b0;
        bus.hdr_fifo_wr_data       = data_q;
        bus.hdr_fifo_wr_last       = 1'b0;
        bus.hdr_fifo_wr_last_entry = 1'b0;
        bus.fetch_done             = fetch_done_q;

        unique case (state_q)
            IDLE: begin
                bus.req_rdy = 1'b1;
                if (bus.req_val) begin
                    idx_d       = bus.req_start_idx;
                    remaining_d = bus.req_num_entries;
                    line_d      = '0;
                    if (bus.req_num_entries == '0) begin
                        fetch_done_d = 1'b1;
                    end else begin
                        state_d = REQ_LINE;
                    end
                end
            end

            REQ_LINE: begin
                bus.rd_req_val = 1'b1;
                if (bus.rd_req_rdy) begin
                    state_d = WAIT_LINE;
                end
            end

            WAIT_LINE: begin
                bus.rd_resp_rdy = 1'b1;
                if (bus.rd_resp_val) begin
                    data_en = 1'b1;
                    if (line_q == '0) begin
                        last_line_d = resp_last_line;
                    end
                    state_d = PUSH_LINE;
                end
            end

            PUSH_LINE: begin
                bus.hdr_fifo_wr_val        = 1'b1;
                bus.hdr_fifo_wr_last       = is_last_line;
                bus.hdr_fifo_wr_last_entry = is_last_entry;
                if (bus.hdr_fifo_wr_rdy) begin
                    if (!is_last_line) begin
                        line_d  = line_q + LINE_W'(1);
                        state_d = REQ_LINE;
                    end else if (!is_last_entry) begin
                        idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                        line_d      = '0;
                        state_d     = REQ_LINE;
                    end else begin
                        fetch_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state and walk counters, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            remaining_q  <= '0;
            line_q       <= '0;
            last_line_q  <= '0;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            remaining_q  <= remaining_d;
            line_q       <= line_d;
            last_line_q  <= last_line_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    // Captured memory line, held for the FIFO push.
    always_ff @(posedge clk) begin
        // NOTE: the wide line register is not reset; it is only observed while wr_val qualifies it.
        if (data_en) begin
            data_q <= bus.rd_resp_data;
        end
    end

endmodule

// File: tb/tb_log_reader_entry_fetch.sv
// Self-checking bench for log_reader_entry_fetch. A transaction-level model
// expands each accepted request into the list of line reads and FIFO writes
// it must produce; a single per-cycle process drives random memory latency
// and FIFO backpressure and compares the DUT against that model.
module tb_log_reader_entry_fetch;

    localparam int DATA_W      = 512;
    localparam int LOG_ENTRIES = 1024;
    localparam int ENTRY_LINES = 4;
    localparam int LEN_W       = 16;
    localparam int IDX_W       = 10;
    localparam int CNT_W       = 8;
    localparam int ADDR_W      = 12;
    localparam int BYTES       = DATA_W / 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              last_entry;
    } wr_t;

    logic clk;
    logic rst;

    log_reader_entry_fetch_if #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) bus ();

    log_reader_entry_fetch #(
        .DATA_W(DATA_W), .LOG_ENTRIES(LOG_ENTRIES), .ENTRY_LINES(ENTRY_LINES),
        .LEN_W(LEN_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model / environment state
    logic [LEN_W-1:0]  len_tab [LOG_ENTRIES];
    logic [ADDR_W-1:0] exp_reads[$];
    wr_t               exp_writes[$];
    logic [ADDR_W-1:0] obs_addrs[$];
    logic [1:0]        obs_flags[$];
    bit                busy, mem_pending, req_pending, done_now, hold_prev, bp_arm;
    int                resp_lat, bp_hold, stray, done_seen, wr_count;
    logic [ADDR_W-1:0] pend_addr;
    logic [IDX_W-1:0]  req_start;
    logic [CNT_W-1:0]  req_num;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last, prev_last_entry;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Memory contents: address-derived pattern, entry length in the low bits of line 0.
    function automatic logic [DATA_W-1:0] line_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) begin
            d[k*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(k) << 20) ^ 32'h5A5A_0000;
        end
        if (a[1:0] == 2'b00) d[LEN_W-1:0] = len_tab[a[ADDR_W-1:2]];
        return d;
    endfunction

    function automatic int lines_for(input logic [LEN_W-1:0] len);
        int n;
        n = (int'(len) + BYTES - 1) / BYTES;
        if (n < 1) n = 1;
        if (n > ENTRY_LINES) n = ENTRY_LINES;
        return n;
    endfunction

    // Expand an accepted request into expected reads and writes.
    task automatic accept(input int start, input int num);
        if (num == 0) begin
            done_now = 1'b1;
        end else begin
            busy = 1'b1;
            for (int e = 0; e < num; e++) begin
                int idx;
                int n;
                idx = (start + e) % LOG_ENTRIES;
                n   = lines_for(len_tab[idx]);
                for (int l = 0; l < n; l++) begin
                    logic [ADDR_W-1:0] a;
                    wr_t w;
                    a = ADDR_W'(idx * ENTRY_LINES + l);
                    w.data       = line_data(a);
                    w.last       = (l == n - 1);
                    w.last_entry = (e == num - 1);
                    exp_reads.push_back(a);
                    exp_writes.push_back(w);
                end
            end
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        logic rd_rdy, wr_rdy, resp_done;
        wr_t  w;
        @(negedge clk);
        check_bit("req_rdy", bus.req_rdy, !busy);
        check_bit("fetch_done", bus.fetch_done, done_now);
        check_bit("rd_resp_rdy", bus.rd_resp_rdy, mem_pending);
        if (bus.fetch_done) done_seen++;
        if (bus.rd_req_val)
            check_bit("rd_req_legal", busy && !mem_pending && !bus.hdr_fifo_wr_val, 1'b1);
        if (bus.hdr_fifo_wr_val)
            check_bit("wr_legal", busy && !mem_pending, 1'b1);
        if (hold_prev) begin
            check_bit("hold_val", bus.hdr_fifo_wr_val, 1'b1);
            check_data("hold_data", bus.hdr_fifo_wr_data, prev_data);
            check_bit("hold_last", bus.hdr_fifo_wr_last, prev_last);
            check_bit("hold_last_entry", bus.hdr_fifo_wr_last_entry, prev_last_entry);
        end
        done_now = 1'b0;

        // Request channel
        bus.req_val         = req_pending;
        bus.req_start_idx   = req_start;
        bus.req_num_entries = req_num;
        if (req_pending && bus.req_rdy) begin
            accept(int'(req_start), int'(req_num));
            req_pending = 1'b0;
        end

        // Memory response with random latency
        resp_done       = 1'b0;
        bus.rd_resp_val = 1'b0;
        if (mem_pending) begin
            if (resp_lat == 0) begin
                bus.rd_resp_val  = 1'b1;
                bus.rd_resp_data = line_data(pend_addr);
                resp_done        = bus.rd_resp_rdy;
            end else begin
                resp_lat--;
            end
        end else if (stray > 0) begin
            bus.rd_resp_val  = 1'b1;
            bus.rd_resp_data = {16{$urandom()}};
            stray--;
        end
        if (resp_done) mem_pending = 1'b0;

        // Memory request acceptance
        rd_rdy         = 1'($urandom_range(0, 1));
        bus.rd_req_rdy = rd_rdy;
        if (bus.rd_req_val && rd_rdy) begin
            check_bit("rd_expected", exp_reads.size() != 0, 1'b1);
            if (exp_reads.size() != 0)
                check_int("rd_addr", int'(bus.rd_req_addr), int'(exp_reads.pop_front()));
            obs_addrs.push_back(bus.rd_req_addr);
            mem_pending = 1'b1;
            pend_addr   = bus.rd_req_addr;
            resp_lat    = int'($urandom_range(0, 3));
        end

        // FIFO write side
        if (bp_arm && bus.hdr_fifo_wr_val) begin
            bp_hold = 10;
            bp_arm  = 1'b0;
        end
        if (bp_hold > 0) begin
            wr_rdy = 1'b0;
            bp_hold--;
        end else begin
            wr_rdy = ($urandom_range(0, 3) != 0);
        end
        bus.hdr_fifo_wr_rdy = wr_rdy;
        hold_prev       = bus.hdr_fifo_wr_val && !wr_rdy;
        prev_data       = bus.hdr_fifo_wr_data;
        prev_last       = bus.hdr_fifo_wr_last;
        prev_last_entry = bus.hdr_fifo_wr_last_entry;
        if (bus.hdr_fifo_wr_val && wr_rdy) begin
            check_bit("wr_expected", exp_writes.size() != 0, 1'b1);
            if (exp_writes.size() != 0) begin
                w = exp_writes.pop_front();
                check_data("wr_data", bus.hdr_fifo_wr_data, w.data);
                check_bit("wr_last", bus.hdr_fifo_wr_last, w.last);
                check_bit("wr_last_entry", bus.hdr_fifo_wr_last_entry, w.last_entry);
                if (exp_writes.size() == 0) begin
                    busy     = 1'b0;
                    done_now = 1'b1;
                end
            end
            obs_flags.push_back({bus.hdr_fifo_wr_last, bus.hdr_fifo_wr_last_entry});
            wr_count++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_val         = 1'b0;
        bus.rd_resp_val     = 1'b0;
        bus.rd_req_rdy      = 1'b0;
        bus.hdr_fifo_wr_rdy = 1'b0;
        busy = 1'b0; mem_pending = 1'b0; req_pending = 1'b0; done_now = 1'b0;
        hold_prev = 1'b0; bp_arm = 1'b0; bp_hold = 0;
        exp_reads.delete();
        exp_writes.delete();
        @(negedge clk);
        @(negedge clk);
        check_bit("rst_req_rdy", bus.req_rdy, 1'b1);
        check_bit("rst_rd_req_val", bus.rd_req_val, 1'b0);
        check_bit("rst_rd_resp_rdy", bus.rd_resp_rdy, 1'b0);
        check_bit("rst_wr_val", bus.hdr_fifo_wr_val, 1'b0);
        check_bit("rst_wr_last", bus.hdr_fifo_wr_last, 1'b0);
        check_bit("rst_wr_last_entry", bus.hdr_fifo_wr_last_entry, 1'b0);
        check_bit("rst_fetch_done", bus.fetch_done, 1'b0);
        rst = 1'b0;
    endtask

    // Issue one request and run it to completion, including the fetch_done cycle.
    task automatic run_req(input int start, input int num);
        int cyc;
        int d0;
        cyc = 0;
        d0  = done_seen;
        req_start   = IDX_W'(start);
        req_num     = CNT_W'(num);
        req_pending = 1'b1;
        do begin
            step();
            cyc++;
        end while ((req_pending || busy) && cyc < 3000);
        check_bit("req_timeout", req_pending || busy, 1'b0);
        step();
        check_int("done_pulses", done_seen - d0, 1);
    endtask

    task automatic directed(input int start, input int num);
        obs_addrs.delete();
        obs_flags.delete();
        run_req(start, num);
    endtask

    initial begin
        int base;
        int cyc;
        rst = 1'b1;
        bus.req_val = 1'b0; bus.req_start_idx = '0; bus.req_num_entries = '0;
        bus.rd_req_rdy = 1'b0; bus.rd_resp_val = 1'b0; bus.rd_resp_data = '0;
        bus.hdr_fifo_wr_rdy = 1'b0;
        stray = 0; done_seen = 0; wr_count = 0; resp_lat = 0; pend_addr = '0;
        for (int i = 0; i < LOG_ENTRIES; i++) begin
            case ($urandom_range(0, 3))
                0:       len_tab[i] = '0;
                1:       len_tab[i] = LEN_W'($urandom_range(1, 64));
                2:       len_tab[i] = LEN_W'($urandom_range(65, 256));
                default: len_tab[i] = LEN_W'($urandom_range(257, 65535));
            endcase
        end
        do_reset();

        // Single entry, 100 bytes -> two lines at 20, 21
        len_tab[5] = 16'd100;
        directed(5, 1);
        check_int("single_nreads", obs_addrs.size(), 2);
        check_int("single_addr0", int'(obs_addrs[0]), 20);
        check_int("single_addr1", int'(obs_addrs[1]), 21);
        check_int("single_flags0", int'(obs_flags[0]), 1);
        check_int("single_flags1", int'(obs_flags[1]), 3);

        // Wrap from the last slot back to 0
        len_tab[1023] = 16'd64; len_tab[0] = 16'd64; len_tab[1] = 16'd64;
        directed(1023, 3);
        check_int("wrap_nreads", obs_addrs.size(), 3);
        check_int("wrap_addr0", int'(obs_addrs[0]), 4092);
        check_int("wrap_addr1", int'(obs_addrs[1]), 0);
        check_int("wrap_addr2", int'(obs_addrs[2]), 4);
        check_int("wrap_flags0", int'(obs_flags[0]), 2);
        check_int("wrap_flags2", int'(obs_flags[2]), 3);

        // Zero count
        base = wr_count;
        directed(300, 0);
        check_int("zero_nreads", obs_addrs.size(), 0);
        check_int("zero_nwrites", wr_count - base, 0);

        // Length clamping: len 0 -> 1 line, len 1000 -> 4 lines
        len_tab[9] = 16'd0; len_tab[10] = 16'd1000;
        directed(9, 2);
        check_int("clamp_nreads", obs_addrs.size(), 5);
        check_int("clamp_addr0", int'(obs_addrs[0]), 36);
        check_int("clamp_addr4", int'(obs_addrs[4]), 43);
        check_int("clamp_flags0", int'(obs_flags[0]), 2);
        check_int("clamp_flags3", int'(obs_flags[3]), 1);
        check_int("clamp_flags4", int'(obs_flags[4]), 3);

        // FIFO backpressure held for 10 cycles on the first write
        len_tab[40] = 16'd200; len_tab[41] = 16'd64;
        bp_arm = 1'b1;
        directed(40, 2);
        check_int("bp_nreads", obs_addrs.size(), 5);
        check_int("bp_addr4", int'(obs_addrs[4]), 164);

        // Reset after two of four lines, stray response afterwards, then rerun
        len_tab[7] = 16'd1000;
        base = wr_count;
        req_start = IDX_W'(7); req_num = CNT_W'(1); req_pending = 1'b1;
        cyc = 0;
        while (wr_count - base < 2 && cyc < 1000) begin
            step();
            cyc++;
        end
        check_int("mid_progress", wr_count - base, 2);
        stray = 3;
        do_reset();
        stray = 3;
        repeat (5) step();
        directed(7, 1);
        check_int("rerun_nreads", obs_addrs.size(), 4);
        check_int("rerun_addr0", int'(obs_addrs[0]), 28);
        check_int("rerun_addr3", int'(obs_addrs[3]), 31);
        check_int("rerun_flags3", int'(obs_flags[3]), 3);

        // Randomized requests, biased toward the wrap point
        for (int i = 0; i < 40; i++) begin
            int s;
            if ($urandom_range(0, 4) == 0)
                s = int'($urandom_range(LOG_ENTRIES - 4, LOG_ENTRIES - 1));
            else
                s = int'($urandom_range(0, LOG_ENTRIES - 1));
            run_req(s, int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/log_reader_entry_fetch.md
Name: log_reader_entry_fetch

Overview:
Upstream feeder of the log reader output controller. Takes a read request (start log index, entry count) and walks a circular log of fixed-size entry slots in line-addressed log memory, one read outstanding at a time. Each entry's lines are pushed into the write-header FIFO with a per-entry last flag. A last_entry flag accompanies the lines of the final requested entry so the downstream controller knows when to close the message.

Parameters:
DATA_W, 512, width of one log memory line / FIFO data word in bits
LOG_ENTRIES, 1024, number of entry slots in the circular log (power of two)
ENTRY_LINES, 4, lines per entry slot (power of two)
LEN_W, 16, width of the byte-length field at bits [LEN_W-1:0] of an entry's first line
IDX_W, 10, log2(LOG_ENTRIES)
CNT_W, 8, width of the entry-count field
ADDR_W, 12, log2(LOG_ENTRIES*ENTRY_LINES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_val  in  1  read request valid
req_start_idx  in  IDX_W  first log index to read
req_num_entries  in  CNT_W  number of entries to read
req_rdy  out  1  request accepted when val&rdy
rd_req_val  out  1  log memory read request valid
rd_req_addr  out  ADDR_W  line address = idx*ENTRY_LINES + line
rd_req_rdy  in  1  memory accepts request
rd_resp_val  in  1  read data valid
rd_resp_data  in  DATA_W  read data
rd_resp_rdy  out  1  ready for read data
hdr_fifo_wr_val  out  1  line valid to write-header FIFO
hdr_fifo_wr_data  out  DATA_W  line data
hdr_fifo_wr_last  out  1  last line of current entry
hdr_fifo_wr_last_entry  out  1  line belongs to the final requested entry
hdr_fifo_wr_rdy  in  1  FIFO ready
fetch_done  out  1  one-cycle pulse when request fully pushed

Behaviour:
- Reset: state IDLE; req_rdy=1; rd_req_val, rd_resp_rdy, hdr_fifo_wr_val, hdr_fifo_wr_last, hdr_fifo_wr_last_entry, fetch_done = 0; counters cleared. Reset mid-request abandons it; an in-flight memory response after reset is not consumed.
- States: IDLE, REQ_LINE, WAIT_LINE, PUSH_LINE.
- IDLE: req_rdy=1. On req_val: latch idx=req_start_idx, remaining=req_num_entries, line=0. If req_num_entries==0 -> fetch_done pulses next cycle, stay IDLE, nothing written. Else -> REQ_LINE.
- REQ_LINE: rd_req_val=1, addr={idx,line[log2(ENTRY_LINES)-1:0]}. On rd_req_rdy -> WAIT_LINE.
- WAIT_LINE: rd_resp_rdy=1. On rd_resp_val capture data into line register -> PUSH_LINE. If line==0, compute entry_lines = max(1, ceil(len/(DATA_W/8))) from bits [LEN_W-1:0], clamped to ENTRY_LINES.
- PUSH_LINE: hdr_fifo_wr_val=1 with captured data; wr_last = (line==entry_lines-1); wr_last_entry = (remaining==1). On hdr_fifo_wr_rdy:
  - not last line: line++ -> REQ_LINE.
  - last line, remaining>1: idx = (idx+1) mod LOG_ENTRIES (wraps LOG_ENTRIES-1 -> 0), remaining--, line=0 -> REQ_LINE.
  - last line, remaining==1: fetch_done=1 that cycle -> IDLE.
- Exactly one memory read outstanding; no line pushed before its response arrives. Output data/flags stable while wr_val && !wr_rdy.
- len==0 treated as one line; len > ENTRY_LINES*DATA_W/8 clamps to ENTRY_LINES lines.
- req_rdy=0 in all states but IDLE; new request accepted only after fetch_done.
- Combinational paths only via state: no rdy->val feedthrough. Response latency arbitrary.

Test Plan:
- Single entry: start=5, num=1, len=100 (DATA_W=512, 2 lines) -> reads addr 20,21; two FIFO writes, second with last=1, last_entry=1 on both; fetch_done one cycle after final write.
- Wrap: start=1023, num=3, each len=64 -> addr 4092, 0, 4; three single-line writes, last=1 each, last_entry only on third.
- Zero count: num=0 -> no rd_req_val, no FIFO writes, fetch_done pulses once, req_rdy stays 1.
- Length clamping: len=0 -> 1 line; len=1000 -> 4 lines (addr idx*4..idx*4+3), last on 4th.
- Backpressure: hold hdr_fifo_wr_rdy=0 for 10 cycles and rd_req_rdy random -> data/flags stable, no second read issued, output sequence unchanged.
- Reset mid-request after 2 of 4 lines -> all outputs 0, req_rdy=1 next cycle, fresh request runs correctly from line 0.
